// File: rtl/xor_cipher_defs.sv
// Shared definitions for the XOR cipher receive path.
// Contents: nibble width, key length limit and the decrypt FSM state encoding.
package xor_cipher_defs;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned MAX_KEY_LEN = 16;

  typedef enum logic [1:0] {
    NOKEY  = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_fifo2.sv
// Two-entry nibble FIFO used as the plaintext output buffer.
// Ports: clk, reset (sync, active-high), push/din write side,
//        pop/dout read side (dout is 0 when empty), count/full/empty status.
// A push while full and a pop while empty are ignored.
module nibble_fifo2
  import xor_cipher_defs::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [NIBBLE_W-1:0] din,
  input  logic                pop,
  output logic [NIBBLE_W-1:0] dout,
  output logic [1:0]          count,
  output logic                full,
  output logic                empty
);

  logic [NIBBLE_W-1:0] mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count_q;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xor_decrypt_stream.sv
// XOR stream decryptor: ciphertext nibbles in over valid/ready, XORed with a
// rotating KEY_LEN-nibble key, plaintext out through a 2-entry buffer.
// Ports: clk, reset (sync, active-high); key_load/key_in key interface
//        (nibble 0 used first); s_valid/s_ready/s_data ciphertext input;
//        m_valid/m_ready/m_data plaintext output; key_ok key-present flag.
// Optional macro XOR_DEC_CHECKSUM_EN adds chk_out, the running XOR of all
// plaintext pushed since the last key load or reset.
module xor_decrypt_stream
  import xor_cipher_defs::*;
#(
  parameter int unsigned KEY_LEN = 4,
  parameter int unsigned DATA_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      key_load,
  input  logic [KEY_LEN*DATA_W-1:0] key_in,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      key_ok
`ifdef XOR_DEC_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]         chk_out
`endif
);

  localparam int unsigned KEY_W = KEY_LEN * DATA_W;
  localparam int unsigned IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  state_e              state_q;
  state_e              state_d;
  logic [KEY_W-1:0]    key_q;
  logic [IDX_W-1:0]    idx_q;
  logic                key_ok_q;
  logic                load_key;
  logic                accept;
  logic                pop;
  logic [DATA_W-1:0]   key_nib;
  logic [DATA_W-1:0]   plain;
  logic [1:0]          fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= NOKEY;
    else       state_q <= state_d;
  end

  // Next state: a key change requested with data buffered waits in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NOKEY:   if (key_load) state_d = ACTIVE;
      ACTIVE:  if (key_load && (fifo_count != 2'd0)) state_d = DRAIN;
      DRAIN:   if (fifo_count == 2'd0) state_d = ACTIVE;
      default: state_d = NOKEY;
    endcase
  end

  // Outputs: s_ready depends only on registered state/occupancy and key_load.
  always_comb begin
    s_ready  = 1'b0;
    load_key = 1'b0;
    case (state_q)
      NOKEY:  load_key = key_load;
      ACTIVE: begin
        s_ready  = ~fifo_full & ~key_load;
        load_key = key_load & (fifo_count == 2'd0);
      end
      DRAIN:  load_key = key_load & (fifo_count == 2'd0);
      default: ;
    endcase
  end

  assign accept = s_valid & s_ready;
  assign pop    = m_valid & m_ready;

  // Current key nibble selected by the rotation index.
  always_comb begin
    key_nib = '0;
    for (int unsigned i = 0; i < KEY_LEN; i++) begin
      if (idx_q == IDX_W'(i)) key_nib = key_q[i*DATA_W +: DATA_W];
    end
  end

  assign plain = s_data ^ key_nib;

  // Key register, rotation index and key-present flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q    <= '0;
      idx_q    <= '0;
      key_ok_q <= 1'b0;
    end else if (load_key) begin
      key_q    <= key_in;
      idx_q    <= '0;
      key_ok_q <= 1'b1;
    end else if (accept) begin
      idx_q <= (idx_q == IDX_W'(KEY_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign key_ok = key_ok_q;

`ifdef XOR_DEC_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;

  // Running XOR of pushed plaintext; load and accept never coincide.
  always_ff @(posedge clk) begin
    if (reset)         chk_q <= '0;
    else if (load_key) chk_q <= '0;
    else if (accept)   chk_q <= chk_q ^ plain;
  end

  assign chk_out = chk_q;
`endif

  nibble_fifo2 u_out_buf (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (plain),
    .pop   (pop),
    .dout  (m_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = ~fifo_empty;

endmodule

// File: tb/tb_xor_decrypt_stream.sv
// Directed and randomized checks of xor_decrypt_stream against a queue-based
// reference model of the decrypt stream.
module tb_xor_decrypt_stream;

  localparam int KL = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            key_load;
  logic [4*KL-1:0] key_in;
  logic            s_valid;
  logic            s_ready;
  logic [3:0]      s_data;
  logic            m_valid;
  logic            m_ready;
  logic [3:0]      m_data;
  logic            key_ok;
`ifdef XOR_DEC_CHECKSUM_EN
  logic [3:0]      chk_out;
`endif

  always #5 clk = ~clk;

  xor_decrypt_stream #(.KEY_LEN(KL), .DATA_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_load (key_load),
    .key_in   (key_in),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .key_ok   (key_ok)
`ifdef XOR_DEC_CHECKSUM_EN
    ,
    .chk_out  (chk_out)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: key as nibble array, plaintext queue, pending-rekey flag.
  logic [3:0]      mkey [KL];
  int              midx;
  logic [3:0]      mq [$];
  bit              mok;
  bit              mpend;
  logic [3:0]      mchk;
  bit              last_acc;
  logic [4*KL-1:0] kreg;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mok   = 1'b0;
    mpend = 1'b0;
    midx  = 0;
    mchk  = 4'h0;
    mq.delete();
    for (int i = 0; i < KL; i++) mkey[i] = 4'h0;
  endtask

  // One clock cycle: drive, compare at negedge, advance the model.
  task automatic cyc(input logic sv, input logic [3:0] sd, input logic mr,
                     input logic kl, input logic [4*KL-1:0] ki, input logic rst);
    logic er, ev, acc, pp, ld;
    logic [3:0] ed, p;
    s_valid = sv; s_data = sd; m_ready = mr; key_load = kl; key_in = ki; reset = rst;
    @(negedge clk);
    er = mok && !mpend && (mq.size() < 2) && !kl;
    ev = (mq.size() != 0);
    ed = ev ? mq[0] : 4'h0;
    chk("s_ready", 4'(s_ready), 4'(er));
    chk("m_valid", 4'(m_valid), 4'(ev));
    chk("m_data",  m_data, ed);
    chk("key_ok",  4'(key_ok), 4'(mok));
`ifdef XOR_DEC_CHECKSUM_EN
    chk("chk_out", chk_out, mchk);
`endif
    acc = sv && er;
    pp  = ev && mr;
    ld  = 1'b0;
    if (!mok) ld = kl;
    else if (!mpend) begin
      if (kl) begin
        if (mq.size() == 0) ld = 1'b1;
        else mpend = 1'b1;
      end
    end else if (mq.size() == 0) begin
      mpend = 1'b0;
      ld    = kl;
    end
    if (pp) void'(mq.pop_front());
    if (acc) begin
      p = sd ^ mkey[midx];
      mq.push_back(p);
      mchk = mchk ^ p;
      midx = (midx + 1) % KL;
    end
    if (ld) begin
      for (int i = 0; i < KL; i++) mkey[i] = ki[4*i +: 4];
      midx = 0;
      mok  = 1'b1;
      mchk = 4'h0;
    end
    if (rst) model_reset();
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  // Hold one nibble valid until accepted, bounded.
  task automatic send(input logic [3:0] d, input logic mr);
    int n;
    n = 0;
    do begin
      cyc(1'b1, d, mr, 1'b0, kreg, 1'b0);
      n++;
    end while (!last_acc && n < 20);
    checks++;
    assert (last_acc) else begin
      errors++;
      $error("FAIL send_timeout observed=%0d expected=1", last_acc);
    end
  endtask

  task automatic idle(input logic mr);
    cyc(1'b0, 4'h0, mr, 1'b0, kreg, 1'b0);
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] d;
    reset = 1'b1; key_load = 1'b0; key_in = '0; s_valid = 1'b0;
    s_data = 4'h0; m_ready = 1'b0; kreg = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // No key: nothing accepted for 10 cycles.
    repeat (10) cyc(1'b1, 4'h7, 1'b1, 1'b0, kreg, 1'b0);

    // Key A5C3, stream 3,C,5,A,3 decrypts to zeros; index wraps on the 5th.
    kreg = 16'hA5C3;
    cyc(1'b0, 4'h0, 1'b1, 1'b1, kreg, 1'b0);
    seq[0] = 4'h3; seq[1] = 4'hC; seq[2] = 4'h5; seq[3] = 4'hA; seq[4] = 4'h3;
    for (int i = 0; i < 5; i++) begin
      send(seq[i], 1'b1);
      chk("t2_mvalid", 4'(m_valid), 4'h1);
      chk("t2_plain", m_data, 4'h0);
    end
    repeat (2) idle(1'b1);

    // Reload, fill with F under backpressure, then release.
    cyc(1'b0, 4'h0, 1'b0, 1'b1, kreg, 1'b0);
    repeat (4) cyc(1'b1, 4'hF, 1'b0, 1'b0, kreg, 1'b0);
    chk("t3_full_ready", 4'(s_ready), 4'h0);
    chk("t3_head", m_data, 4'hC);
    send(4'hF, 1'b1);
    chk("t3_third", m_data, 4'hA);
    repeat (3) idle(1'b1);

    // Rekey with two buffered: drain first, then new key 1111.
    send(4'h6, 1'b0);
    send(4'h9, 1'b0);
    repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'h1111, 1'b0);
    chk("t4_drain_ready", 4'(s_ready), 4'h0);
    repeat (3) cyc(1'b0, 4'h0, 1'b1, 1'b1, 16'h1111, 1'b0);
    kreg = 16'h1111;
    send(4'h1, 1'b1);
    chk("t4_newkey_plain", m_data, 4'h0);
    repeat (2) idle(1'b1);

    // Steady push+pop with one entry buffered.
    send(4'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      d = 4'($urandom);
      send(d, 1'b1);
      chk("t5_count1", 4'(m_valid), 4'h1);
    end
    repeat (2) idle(1'b1);

    // Reset with two buffered.
    send(4'h2, 1'b0);
    send(4'h4, 1'b0);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, kreg, 1'b1);
    chk("t6_mvalid", 4'(m_valid), 4'h0);
    chk("t6_keyok", 4'(key_ok), 4'h0);
    chk("t6_sready", 4'(s_ready), 4'h0);
    repeat (2) cyc(1'b1, 4'h5, 1'b1, 1'b0, kreg, 1'b0);

`ifdef XOR_DEC_CHECKSUM_EN
    // Checksum of 3,C,5,A under a zero key is zero, and reset clears it.
    kreg = '0;
    cyc(1'b0, 4'h0, 1'b1, 1'b1, kreg, 1'b0);
    for (int i = 0; i < 4; i++) send(seq[i], 1'b1);
    chk("t7_chk", chk_out, 4'h0);
    send(4'h9, 1'b1);
    chk("t7_chk9", chk_out, 4'h9);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, kreg, 1'b1);
    chk("t7_chk_rst", chk_out, 4'h0);
`endif

    // Randomized traffic with occasional rekeys and resets.
    kreg = 16'($urandom);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, kreg, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic kl, rst;
      kl  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 149) == 0);
      if (kl) kreg = 16'($urandom);
      cyc(1'($urandom), 4'($urandom), 1'($urandom), kl, kreg, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
